// File: rtl/connect4_pkg.sv
// Shared Connect Four types: cell colour codes, default board size and the
// drop/turn controller state encoding.
package connect4_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    RED   = 2'b01,
    GREEN = 2'b10
  } color_t;

  localparam int DEF_ROWS       = 6;
  localparam int DEF_COLS       = 7;
  localparam int DEF_COLW       = 3;
  localparam int DEF_FALL_TICKS = 4;

  typedef enum logic [1:0] {
    IDLE,
    FALL,
    PLACE,
    DONE
  } ctrl_state_t;

  function automatic color_t other_player(input color_t c);
    return (c == GREEN) ? RED : GREEN;
  endfunction

endpackage

// File: rtl/drop_turn_ctrl_if.sv
// Player-side strobes and cell-array/status outputs of the drop/turn controller.
interface drop_turn_ctrl_if #(
  parameter int ROWS = 6,
  parameter int COLS = 7,
  parameter int COLW = 3
) ();
  logic [1:0]               drop_req;
  logic [COLW-1:0]          green_col;
  logic [COLW-1:0]          red_col;
  logic [2*ROWS*COLS-1:0]   up_bus;
  logic [1:0]               turn;
  logic                     busy;
  logic                     reject;
  logic                     board_full;
  logic                     fall_valid;
  logic [$clog2(ROWS)-1:0]  fall_row;
  logic [COLW-1:0]          fall_col;

  modport master (
    output drop_req, green_col, red_col,
    input  up_bus, turn, busy, reject, board_full, fall_valid, fall_row, fall_col
  );

  modport slave (
    input  drop_req, green_col, red_col,
    output up_bus, turn, busy, reject, board_full, fall_valid, fall_row, fall_col
  );
endinterface

// File: rtl/column_height_tracker.sv
// Per-column saturating fill heights plus a total-fill counter for board_full.
module column_height_tracker #(
  parameter int ROWS = 6,
  parameter int COLS = 7,
  parameter int COLW = 3,
  parameter int HW   = $clog2(ROWS + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            inc_i,
  input  logic [COLW-1:0] col_i,
  output logic [HW-1:0]   height_o [COLS],
  output logic [COLS-1:0] full_o,
  output logic            last_o,
  output logic            board_full_o
);
  localparam int TOTAL = ROWS * COLS;
  localparam int CW    = $clog2(TOTAL + 1);

  logic [HW-1:0] height_q [COLS];
  logic [CW-1:0] count_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      // NOTE: this is a handful of flops, not a RAM, so a full reset is cheap and required.
      for (int c = 0; c < COLS; c++) height_q[c] <= '0;
      count_q <= '0;
    end else if (inc_i && int'(col_i) < COLS && height_q[col_i] != HW'(ROWS)) begin
      height_q[col_i] <= height_q[col_i] + 1'b1;
      count_q         <= count_q + 1'b1;
    end
  end

  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      height_o[c] = height_q[c];
      full_o[c]   = (height_q[c] == HW'(ROWS));
    end
  end

  assign last_o       = (count_q == CW'(TOTAL - 1));
  assign board_full_o = (count_q == CW'(TOTAL));

endmodule

// File: rtl/drop_turn_ctrl.sv
// Connect Four turn arbiter and piece-drop sequencer; DROP_ANIM_EN adds the
// animated FALL phase before each placement.
module drop_turn_ctrl
  import connect4_pkg::*;
#(
  parameter int ROWS       = DEF_ROWS,
  parameter int COLS       = DEF_COLS,
  parameter int COLW       = DEF_COLW,
  parameter int FALL_TICKS = DEF_FALL_TICKS
) (
  input logic             clock,
  input logic             reset,
  drop_turn_ctrl_if.slave bus
);
  localparam int UPW = 2 * ROWS * COLS;
  localparam int RW  = $clog2(ROWS);
  localparam int HW  = $clog2(ROWS + 1);

  generate
    if (FALL_TICKS < 1 || (1 << COLW) < COLS) begin : g_bad_cfg
      $error("drop_turn_ctrl: illegal FALL_TICKS/COLW configuration");
    end
  endgenerate

  ctrl_state_t     state_q;
  color_t          turn_q;
  logic [COLW-1:0] col_q;
  logic [RW-1:0]   row_q;
  logic [UPW-1:0]  up_bus_q;
  logic            busy_q;
  logic            reject_q;

  logic [HW-1:0]        heights [COLS];
  logic [COLS-1:0]      full;
  logic [2**COLW-1:0]   full_ext;
  logic                 last_fill;
  logic                 board_full;
  logic                 req;
  logic [COLW-1:0]      sel_col;
  logic [RW-1:0]        sel_row;
  logic                 sel_ok;

  column_height_tracker #(
    .ROWS(ROWS), .COLS(COLS), .COLW(COLW), .HW(HW)
  ) u_heights (
    .clock       (clock),
    .reset       (reset),
    .inc_i       (state_q == PLACE),
    .col_i       (col_q),
    .height_o    (heights),
    .full_o      (full),
    .last_o      (last_fill),
    .board_full_o(board_full)
  );

  // Only the player whose turn it is can be heard; the other strobe is dropped.
  always_comb begin
    full_ext           = '1;
    full_ext[COLS-1:0] = full;
    req     = (turn_q == GREEN) ? bus.drop_req[1] : bus.drop_req[0];
    sel_col = (turn_q == GREEN) ? bus.green_col   : bus.red_col;
    sel_ok  = !full_ext[sel_col];
    sel_row = RW'(heights[sel_col]);
  end

  function automatic logic [UPW-1:0] cell_pulse(input logic [RW-1:0] row,
                                                input logic [COLW-1:0] col,
                                                input color_t c);
    logic [UPW-1:0] v;
    int idx;
    v   = '0;
    idx = int'(row) * COLS + int'(col);
    v[2*idx +: 2] = c;
    return v;
  endfunction

`ifdef DROP_ANIM_EN
  localparam int TW = (FALL_TICKS > 1) ? $clog2(FALL_TICKS) : 1;
  logic            fall_valid_q;
  logic [RW-1:0]   fall_row_q;
  logic [COLW-1:0] fall_col_q;
  logic [TW-1:0]   tick_q;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      turn_q   <= GREEN;
      col_q    <= '0;
      row_q    <= '0;
      up_bus_q <= '0;
      busy_q   <= 1'b0;
      reject_q <= 1'b0;
`ifdef DROP_ANIM_EN
      fall_valid_q <= 1'b0;
      fall_row_q   <= '0;
      fall_col_q   <= '0;
      tick_q       <= '0;
`endif
    end else begin
      // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
      up_bus_q <= '0;
      reject_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            if (!sel_ok) begin
              reject_q <= 1'b1;
            end else begin
              col_q  <= sel_col;
              row_q  <= sel_row;
              busy_q <= 1'b1;
`ifdef DROP_ANIM_EN
              if (sel_row == RW'(ROWS - 1)) begin
                state_q  <= PLACE;
                up_bus_q <= cell_pulse(sel_row, sel_col, turn_q);
              end else begin
                state_q      <= FALL;
                fall_valid_q <= 1'b1;
                fall_row_q   <= RW'(ROWS - 1);
                fall_col_q   <= sel_col;
                tick_q       <= '0;
              end
`else
              state_q  <= PLACE;
              up_bus_q <= cell_pulse(sel_row, sel_col, turn_q);
`endif
            end
          end
        end
        FALL: begin
`ifdef DROP_ANIM_EN
          if (tick_q == TW'(FALL_TICKS - 1)) begin
            tick_q     <= '0;
            fall_row_q <= fall_row_q - 1'b1;
            if (RW'(fall_row_q - 1'b1) == row_q) begin
              state_q      <= PLACE;
              fall_valid_q <= 1'b0;
              up_bus_q     <= cell_pulse(row_q, col_q, turn_q);
            end
          end else begin
            tick_q <= tick_q + 1'b1;
          end
`else
          state_q <= IDLE;
`endif
        end
        PLACE: begin
          turn_q <= other_player(turn_q);
          if (last_fill) begin
            state_q <= DONE;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        DONE: ;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.up_bus     = up_bus_q;
  assign bus.turn       = turn_q;
  assign bus.busy       = busy_q;
  assign bus.reject     = reject_q;
  assign bus.board_full = board_full;
`ifdef DROP_ANIM_EN
  assign bus.fall_valid = fall_valid_q;
  assign bus.fall_row   = fall_row_q;
  assign bus.fall_col   = fall_col_q;
`else
  assign bus.fall_valid = 1'b0;
  assign bus.fall_row   = '0;
  assign bus.fall_col   = '0;
`endif

endmodule
